// File: rtl/rot_pkg.sv
// rot_pkg: shared rotation-angle and FSM state types for the image rotation stage
package rot_pkg;
  typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;
  typedef enum logic {LOAD, EMIT} state_e;
endpackage

// File: rtl/rot_addr_gen.sv
// rot_addr_gen: maps an output (row, col) and clockwise angle to the row-major source address
module rot_addr_gen
  import rot_pkg::*;
#(
  parameter int IMG_DIM = 28
) (
  input  logic [$clog2(IMG_DIM)-1:0]         r,
  input  logic [$clog2(IMG_DIM)-1:0]         c,
  input  logic [1:0]                         rot,
  output logic [$clog2(IMG_DIM*IMG_DIM)-1:0] addr
);
  localparam int CW = $clog2(IMG_DIM);
  localparam int AW = $clog2(IMG_DIM*IMG_DIM);
  localparam logic [CW-1:0] MAX = CW'(IMG_DIM - 1);
  logic [CW-1:0] sr, sc;
  always_comb begin
    sr = rot == ROT_0 ? r : rot == ROT_90 ? MAX - c : rot == ROT_180 ? MAX - r : c;
    sc = rot == ROT_0 ? c : rot == ROT_90 ? r : rot == ROT_180 ? MAX - c : MAX - r;
    addr = AW'(sr) * AW'(IMG_DIM) + AW'(sc);
  end
endmodule

// File: rtl/image_rotate.sv
// image_rotate: single-buffered square frame store that re-emits the image rotated clockwise by 0/90/180/270
module image_rotate
  import rot_pkg::*;
#(
  parameter int IMG_DIM = 28,
  parameter int PIX_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       degrees,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  output logic             rot_done
);
  localparam int CW   = $clog2(IMG_DIM);
  localparam int AW   = $clog2(IMG_DIM*IMG_DIM);
  localparam int NPIX = IMG_DIM * IMG_DIM;
  localparam logic [CW-1:0] MAX  = CW'(IMG_DIM - 1);
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
  state_e state_q, state_d;
  rot_e rot_q, rot_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d, src_addr;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_last_q, out_last_d, rot_done_q, rot_done_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic [PIX_W-1:0] mem [NPIX];
  logic wr_en, load, last_hs;
  assign wr_en   = in_valid & in_ready_q;
  assign last_hs = out_valid_q & out_ready & out_last_q;
  // out_last_q stays up until its handshake, which blocks any further loads in this frame
  assign load    = (state_q == EMIT) & (!out_valid_q | out_ready) & !out_last_q;
  rot_addr_gen #(.IMG_DIM(IMG_DIM)) u_addr (
    .r   (r_q),
    .c   (c_q),
    .rot (rot_q),
    .addr(src_addr)
  );
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= in_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      rot_q       <= ROT_0;
      wr_cnt_q    <= '0;
      r_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      rot_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rot_q       <= rot_d;
      wr_cnt_q    <= wr_cnt_d;
      r_q         <= r_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      rot_done_q  <= rot_done_d;
    end
  end
  always_comb begin
    state_d = (state_q == LOAD && wr_en && wr_cnt_q == LAST) ? EMIT : last_hs ? LOAD : state_q;
  end
  always_comb begin
    wr_cnt_d    = wr_en ? (wr_cnt_q == LAST ? '0 : wr_cnt_q + AW'(1)) : wr_cnt_q;
    rot_d       = (wr_en && wr_cnt_q == '0) ? rot_e'(degrees) : rot_q;
    in_ready_d  = state_d == LOAD;
    c_d         = load ? (c_q == MAX ? '0 : c_q + CW'(1)) : c_q;
    r_d         = (load && c_q == MAX) ? (r_q == MAX ? '0 : r_q + CW'(1)) : r_q;
    out_valid_d = load | (out_valid_q & !out_ready);
    out_data_d  = load ? mem[src_addr] : out_data_q;
    out_last_d  = load ? (r_q == MAX && c_q == MAX) : last_hs ? 1'b0 : out_last_q;
    rot_done_d  = last_hs;
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign rot_done  = rot_done_q;
endmodule

// File: doc/image_rotate.md
Name: image_rotate

Overview:
- Frame-buffered rotation stage that sits directly downstream of the rotation-angle LFSR in the augmentation chain.
- Accepts one square greyscale image as a row-major pixel stream and stores it.
- Emits the image row-major, rotated clockwise by 0/90/180/270 degrees according to the 2-bit angle code.
- Pulses rot_done when a frame has fully left the block; rot_done drives the LFSR enable so each image gets a fresh angle.

Parameters:
- IMG_DIM, 28, image side length in pixels (image is IMG_DIM x IMG_DIM).
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- degrees  in  2  rotation code from LFSR: 0=0°, 1=90° cw, 2=180°, 3=270° cw
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept input pixel
- in_data  in  PIX_W  input pixel, row-major order
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output pixel
- out_data  out  PIX_W  rotated pixel, row-major order
- out_last  out  1  high with the final pixel of a frame
- rot_done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first LOAD cycle after it; out_valid=0, out_data=0, out_last=0, rot_done=0. State is LOAD, all counters are 0, latched angle is 0.
- Storage: IMG_DIM*IMG_DIM x PIX_W buffer with combinational (LUTRAM) read. The frame is single-buffered, so input and output never overlap.
- FSM state LOAD:
  - in_ready=1.
  - Each accepted pixel (in_valid & in_ready) is written at wr_cnt, then wr_cnt increments.
  - On the first accepted pixel (wr_cnt==0), degrees is latched into rot_q.
  - Accepting pixel N*N-1 clears wr_cnt and moves to EMIT on the next cycle.
- FSM state EMIT:
  - in_ready=0.
  - The output counter runs over (r,c) in row-major order.
  - Source address for rot_q:
    - 0: (r, c)
    - 1: (N-1-c, r)
    - 2: (N-1-r, N-1-c)
    - 3: (c, N-1-r)
  - out_valid, out_data and out_last are registers. They load the next pixel when (!out_valid | out_ready) and pixels remain.
  - First out_valid appears 1 cycle after entering EMIT. With out_ready held high, throughput is 1 pixel/cycle.
  - out_data and out_last hold stable while out_valid & !out_ready.
  - out_last=1 only on pixel index N*N-1.
  - After the out_last handshake: out_valid drops next cycle unless reloaded, rot_done=1 for exactly that one cycle, the state returns to LOAD, and all counters clear.
- Width rules: counters are $clog2(IMG_DIM) bits per axis and the address is $clog2(IMG_DIM*IMG_DIM) bits. N-1-x is computed at counter width with no overflow.
- Boundary conditions:
  - degrees changing mid-frame is ignored; only rot_q is used.
  - in_valid during EMIT is not accepted.
  - out_ready low indefinitely stalls with no data loss.
  - Reset mid-frame discards the partial frame and restarts in LOAD.

Decomposition:
- Package rot_pkg:
  - typedef enum logic [1:0] rot_e {ROT_0, ROT_90, ROT_180, ROT_270}.
  - typedef enum logic state_e {LOAD, EMIT}.
- Sub-module rot_addr_gen: combinational (r, c, rot_q) -> source address. It is tested standalone exhaustively for IMG_DIM=3 and 28.

Test Plan:
- IMG_DIM=3, pixels 0..8, degrees=0, out_ready=1 -> output 0,1,2,3,4,5,6,7,8; out_last on 8; rot_done pulses 1 cycle after.
- degrees=1 -> 6,3,0,7,4,1,8,5,2.
- degrees=2 -> 8,7,6,5,4,3,2,1,0.
- degrees=3 -> 2,5,8,1,4,7,0,3,6.
- degrees=1 latched, switched to 3 after the first pixel; out_ready toggled 1/0 randomly -> sequence still 6,3,0,7,4,1,8,5,2; out_data stable during stalls; no drops or duplicates.
- Reset asserted after 4 input pixels, then a full frame with degrees=2 -> only the new frame is emitted (8..0); in_ready=0 during EMIT; rot_done pulses once per frame across 3 back-to-back frames.
